// File: rtl/rs_dec_pkg.sv
// Shared constants, FSM state type and helpers for the RS(204,188) decoder feeder.
package rs_dec_pkg;

    localparam int RS_N          = 204;
    localparam int RS_K          = 188;
    localparam int CE_PERIOD_MIN = 8;

    localparam int CNT_W      = 8;
    localparam int TIMER_W    = 8;
    localparam int INFLIGHT_W = 3;
    localparam int STAT_W     = 16;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_SETTLE,
        ST_IDLE,
        ST_STROBE,
        ST_GAP
    } feed_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/rs_dec_feeder_if.sv
// Upstream byte stream and framed decoded-output stream of the RS decoder feeder.
interface rs_dec_feeder_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_sof;
    logic       s_ready;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_sof;
    logic       m_eof;

    modport master (
        output s_data, s_valid, s_sof,
        input  s_ready,
        input  m_data, m_valid, m_sof, m_eof
    );

    modport slave (
        input  s_data, s_valid, s_sof,
        output s_ready,
        output m_data, m_valid, m_sof, m_eof
    );

endinterface

// File: rtl/rs_dec_out_framer.sv
// Registers decoder output bytes and frames them into 188-byte blocks with sof/eof.
module rs_dec_out_framer
    import rs_dec_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] dec_out,
    input  logic       dec_ceo,
    input  logic       dec_valid,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_sof,
    output logic       m_eof,
    output logic       eof_pulse
);

    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(RS_K - 1);

    logic [CNT_W-1:0] out_cnt;
    logic             take;

    assign take = dec_ceo && dec_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            out_cnt <= '0;
        end else begin
            m_valid <= take;
            m_sof   <= take && (out_cnt == '0);
            m_eof   <= take && (out_cnt == OUT_LAST);
            if (take) begin
                m_data <= dec_out;
            end
            // A resync clears the position even if a byte is taken this cycle.
            if (clear) begin
                out_cnt <= '0;
            end else if (take) begin
                out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + CNT_W'(1);
            end
        end
    end

    assign eof_pulse = m_eof;

endmodule

// File: rtl/rs_dec_feeder.sv
// Paces bytes into RS_dec with a CE strobe, handles resync and frames decoder output.
// Optional statistics counters are built when RS_FEED_STATS_EN is defined.
module rs_dec_feeder
    import rs_dec_pkg::*;
#(
    parameter int CE_PERIOD    = 8,
    parameter int RST_CYCLES   = 6,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic              clk,
    input  logic              reset,
    rs_dec_feeder_if.slave    bus,
    output logic              dec_reset,
    output logic              dec_ce,
    output logic [7:0]        dec_in,
    input  logic [7:0]        dec_out,
    input  logic              dec_ceo,
    input  logic              dec_valid,
    output logic              sync_err,
    output logic [STAT_W-1:0] blk_in_cnt,
    output logic [STAT_W-1:0] blk_out_cnt,
    output logic [STAT_W-1:0] sync_err_cnt
);

    localparam logic [TIMER_W-1:0]    RST_LAST = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    GAP_LAST = TIMER_W'(CE_PERIOD - 3);
    localparam logic [CNT_W-1:0]      IN_LAST  = CNT_W'(RS_N - 1);
    localparam logic [INFLIGHT_W-1:0] MAX_IF   = INFLIGHT_W'(MAX_INFLIGHT);

    feed_state_t             state;
    feed_state_t             state_next;
    logic [TIMER_W-1:0]      timer;
    logic [CNT_W-1:0]        in_cnt;
    logic [INFLIGHT_W-1:0]   inflight;
    logic                    pending;
    logic                    s_ready_int;
    logic                    accept;
    logic                    resync;
    logic                    blk_done;
    logic                    eof_pulse;

    assign accept   = bus.s_valid && s_ready_int;
    assign resync   = accept && bus.s_sof && (in_cnt != '0);
    assign blk_done = dec_ce && (in_cnt == IN_LAST);
    assign bus.s_ready = s_ready_int;

    // The timer restarts on every state change and measures time spent in the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FLUSH;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= (state_next != state) ? '0 : timer + TIMER_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FLUSH:  if (timer == RST_LAST) state_next = ST_SETTLE;
            ST_SETTLE: if (timer == TIMER_W'(1)) state_next = pending ? ST_STROBE : ST_IDLE;
            ST_IDLE:   if (accept) state_next = resync ? ST_FLUSH : ST_STROBE;
            ST_STROBE: state_next = ST_GAP;
            ST_GAP:    if (timer == GAP_LAST) state_next = ST_IDLE;
            default:   state_next = ST_FLUSH;
        endcase
    end

    // New blocks stall once too many codewords are inside the decoder; a started block never does.
    always_comb begin
        dec_reset   = 1'b0;
        dec_ce      = 1'b0;
        s_ready_int = 1'b0;
        case (state)
            ST_FLUSH:  dec_reset = 1'b1;
            ST_IDLE:   s_ready_int = (in_cnt != '0) || (inflight < MAX_IF);
            ST_STROBE: dec_ce = 1'b1;
            default:   ;
        endcase
    end

    // A misaligned sof restarts the decoder; the byte that carried it is replayed as byte 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_in   <= '0;
            in_cnt   <= '0;
            inflight <= '0;
            pending  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= resync;
            if (accept) begin
                dec_in <= bus.s_data;
            end
            if (resync) begin
                pending <= 1'b1;
            end else if (dec_ce) begin
                pending <= 1'b0;
            end
            if (resync) begin
                in_cnt <= '0;
            end else if (dec_ce) begin
                in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + CNT_W'(1);
            end
            if (resync) begin
                inflight <= '0;
            end else if (blk_done && !eof_pulse) begin
                inflight <= inflight + INFLIGHT_W'(1);
            end else if (eof_pulse && !blk_done && (inflight != '0)) begin
                inflight <= inflight - INFLIGHT_W'(1);
            end
        end
    end

    rs_dec_out_framer u_framer (
        .clk       (clk),
        .reset     (reset),
        .clear     (resync),
        .dec_out   (dec_out),
        .dec_ceo   (dec_ceo),
        .dec_valid (dec_valid),
        .m_data    (bus.m_data),
        .m_valid   (bus.m_valid),
        .m_sof     (bus.m_sof),
        .m_eof     (bus.m_eof),
        .eof_pulse (eof_pulse)
    );

`ifdef RS_FEED_STATS_EN
    // Statistics survive resyncs; only the hardware reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_in_cnt   <= '0;
            blk_out_cnt  <= '0;
            sync_err_cnt <= '0;
        end else begin
            if (blk_done)  blk_in_cnt   <= sat_inc(blk_in_cnt);
            if (eof_pulse) blk_out_cnt  <= sat_inc(blk_out_cnt);
            if (resync)    sync_err_cnt <= sat_inc(sync_err_cnt);
        end
    end
`else
    assign blk_in_cnt   = '0;
    assign blk_out_cnt  = '0;
    assign sync_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rs_dec_feeder.sv
// Directed testbench for rs_dec_feeder: reset/flush timing, pacing, inflight stall, framing, resync.
module tb_rs_dec_feeder;
    import rs_dec_pkg::*;

`ifdef RS_FEED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int CE = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  dec_out = '0;
    logic        dec_ceo = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_reset;
    logic        dec_ce;
    logic [7:0]  dec_in;
    logic        sync_err;
    logic [15:0] blk_in_cnt;
    logic [15:0] blk_out_cnt;
    logic [15:0] sync_err_cnt;

    rs_dec_feeder_if bus ();

    rs_dec_feeder #(.CE_PERIOD(CE), .RST_CYCLES(6), .MAX_INFLIGHT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dec_reset    (dec_reset),
        .dec_ce       (dec_ce),
        .dec_in       (dec_in),
        .dec_out      (dec_out),
        .dec_ceo      (dec_ceo),
        .dec_valid    (dec_valid),
        .sync_err     (sync_err),
        .blk_in_cnt   (blk_in_cnt),
        .blk_out_cnt  (blk_out_cnt),
        .sync_err_cnt (sync_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pass_cnt = 0;
    int         check_cnt = 0;

    int         ce_cyc_q[$];
    logic [7:0] ce_dat_q[$];
    int         m_cyc_q[$];
    logic [7:0] m_dat_q[$];
    logic       m_sof_q[$];
    logic       m_eof_q[$];
    int         rise_q[$];
    int         sync_cnt = 0;
    int         drst_cnt = 0;
    logic       prev_ready = 1'b0;

    // Passive recorders, sampled on the falling edge.
    always @(negedge clk) begin
        if (dec_ce) begin
            ce_cyc_q.push_back(cyc);
            ce_dat_q.push_back(dec_in);
        end
        if (bus.m_valid) begin
            m_cyc_q.push_back(cyc);
            m_dat_q.push_back(bus.m_data);
            m_sof_q.push_back(bus.m_sof);
            m_eof_q.push_back(bus.m_eof);
        end
        if (sync_err) sync_cnt++;
        if (dec_reset) drst_cnt++;
        if (bus.s_ready && !prev_ready) rise_q.push_back(cyc);
        prev_ready = bus.s_ready;
    end

    logic [7:0] tx_d[$];
    logic       tx_s[$];
    logic [7:0] hist_d[$];
    int         drv_cyc_q[$];
    int         last_acc_cyc = 0;
    bit         send_timeout = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic queue_bytes(input int n, input int first_idx, input int seed);
        for (int i = 0; i < n; i++) begin
            tx_d.push_back(8'((seed + i * 37) & 255));
            tx_s.push_back(((first_idx + i) % RS_N) == 0);
        end
    endtask

    task automatic send_bytes(input int budget);
        int   left;
        logic acc;
        left = budget;
        while (tx_d.size() != 0 && left > 0) begin
            bus.s_data  = tx_d[0];
            bus.s_sof   = tx_s[0];
            bus.s_valid = 1'b1;
            acc = bus.s_ready;
            tick();
            left--;
            if (acc) begin
                last_acc_cyc = cyc;
                hist_d.push_back(tx_d[0]);
                void'(tx_d.pop_front());
                void'(tx_s.pop_front());
            end
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        send_timeout = (tx_d.size() != 0);
        tx_d.delete();
        tx_s.delete();
    endtask

    task automatic emit_block(input int base);
        for (int v = 0; v < RS_K; v++) begin
            dec_out = 8'((v + base) & 255);
            dec_ceo = 1'b1;
            dec_valid = 1'b1;
            drv_cyc_q.push_back(cyc);
            tick();
            dec_out = 8'hEE;
            dec_valid = 1'b0;
            tick();
            dec_ceo = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset(input string tag);
        reset = 1'b0;
        #1;
        check_cnt++;
        if (dec_reset !== 1'b1) $display("[TB] FAIL %s dec_reset in reset: got %b, expected 1", tag, dec_reset);
        else pass_cnt++;
        check_cnt++;
        if ({bus.s_ready, dec_ce, sync_err, bus.m_valid, bus.m_sof, bus.m_eof} !== 6'b0)
            $display("[TB] FAIL %s strobes in reset: got %b, expected 000000", tag,
                     {bus.s_ready, dec_ce, sync_err, bus.m_valid, bus.m_sof, bus.m_eof});
        else pass_cnt++;
        check_cnt++;
        if ({dec_in, bus.m_data} !== 16'h0) $display("[TB] FAIL %s data in reset: got %h, expected 0000", tag, {dec_in, bus.m_data});
        else pass_cnt++;
        check_cnt++;
        if ({blk_in_cnt, blk_out_cnt, sync_err_cnt} !== 48'h0)
            $display("[TB] FAIL %s stats in reset: got %h, expected 0", tag, {blk_in_cnt, blk_out_cnt, sync_err_cnt});
        else pass_cnt++;
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) tick();
            check_cnt++;
            if (dec_reset !== (i <= 5)) $display("[TB] FAIL %s dec_reset at %0d: got %b, expected %b", tag, i, dec_reset, (i <= 5));
            else pass_cnt++;
            check_cnt++;
            if (bus.s_ready !== (i == 8)) $display("[TB] FAIL %s s_ready at %0d: got %b, expected %b", tag, i, bus.s_ready, (i == 8));
            else pass_cnt++;
        end
    endtask

    task automatic test_block();
        int b, h;
        b = ce_cyc_q.size();
        h = hist_d.size();
        queue_bytes(RS_N, 0, 11);
        send_bytes(RS_N * CE + 64);
        check_cnt++;
        if (send_timeout !== 1'b0) $display("[TB] FAIL block1 send: got timeout, expected completion");
        else pass_cnt++;
        repeat (3) tick();
        check_cnt++;
        if (ce_cyc_q.size() - b !== RS_N) $display("[TB] FAIL block1 strobe count: got %0d, expected %0d", ce_cyc_q.size() - b, RS_N);
        else pass_cnt++;
        for (int i = 0; i < RS_N && (b + i) < ce_cyc_q.size() && (h + i) < hist_d.size(); i++) begin
            check_cnt++;
            if (ce_dat_q[b + i] !== hist_d[h + i]) $display("[TB] FAIL block1 dec_in[%0d]: got %h, expected %h", i, ce_dat_q[b + i], hist_d[h + i]);
            else pass_cnt++;
            if (i > 0) begin
                check_cnt++;
                if (ce_cyc_q[b + i] - ce_cyc_q[b + i - 1] !== CE)
                    $display("[TB] FAIL block1 ce spacing[%0d]: got %0d, expected %0d", i, ce_cyc_q[b + i] - ce_cyc_q[b + i - 1], CE);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (blk_in_cnt !== (STATS ? 16'd1 : 16'd0)) $display("[TB] FAIL block1 blk_in_cnt: got %0d, expected %0d", blk_in_cnt, STATS ? 1 : 0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int b;
        b = ce_cyc_q.size();
        queue_bytes(RS_N, 0, 23);
        send_bytes(RS_N * CE + 64);
        check_cnt++;
        if (send_timeout !== 1'b0) $display("[TB] FAIL block2 send: got timeout, expected completion");
        else pass_cnt++;
        repeat (3) tick();
        check_cnt++;
        if (ce_cyc_q.size() - b !== RS_N) $display("[TB] FAIL block2 strobe count: got %0d, expected %0d", ce_cyc_q.size() - b, RS_N);
        else pass_cnt++;
        tx_d.push_back(8'h5A);
        tx_s.push_back(1'b1);
        send_bytes(30);
        check_cnt++;
        if (send_timeout !== 1'b1) $display("[TB] FAIL block3 stall: got accepted, expected s_ready low");
        else pass_cnt++;
    endtask

    task automatic test_output();
        int md, dd, rb, b, exp_rise;
        md = m_cyc_q.size();
        dd = drv_cyc_q.size();
        rb = rise_q.size();
        b  = ce_cyc_q.size();
        tx_d.push_back(8'h5A);
        tx_s.push_back(1'b1);
        fork
            emit_block(0);
            send_bytes(RS_K * 3 + 40);
        join
        check_cnt++;
        if (send_timeout !== 1'b0) $display("[TB] FAIL block3 resume: got timeout, expected accept after m_eof");
        else pass_cnt++;
        repeat (2) tick();
        check_cnt++;
        if (m_cyc_q.size() - md !== RS_K) $display("[TB] FAIL m_valid count: got %0d, expected %0d", m_cyc_q.size() - md, RS_K);
        else pass_cnt++;
        for (int i = 0; i < RS_K && (md + i) < m_cyc_q.size(); i++) begin
            check_cnt++;
            if ({m_dat_q[md + i], m_sof_q[md + i], m_eof_q[md + i]} !== {8'(i), (i == 0), (i == RS_K - 1)})
                $display("[TB] FAIL m byte %0d: got data=%0d sof=%b eof=%b, expected data=%0d sof=%b eof=%b", i,
                         m_dat_q[md + i], m_sof_q[md + i], m_eof_q[md + i], i, (i == 0), (i == RS_K - 1));
            else pass_cnt++;
            check_cnt++;
            if (m_cyc_q[md + i] !== drv_cyc_q[dd + i] + 1)
                $display("[TB] FAIL m latency %0d: got cycle %0d, expected %0d", i, m_cyc_q[md + i], drv_cyc_q[dd + i] + 1);
            else pass_cnt++;
        end
        exp_rise = drv_cyc_q[dd + RS_K - 1] + 2;
        check_cnt++;
        if (rise_q.size() <= rb) $display("[TB] FAIL s_ready after m_eof: got no rise, expected cycle %0d", exp_rise);
        else if (rise_q[rb] !== exp_rise) $display("[TB] FAIL s_ready after m_eof: got cycle %0d, expected %0d", rise_q[rb], exp_rise);
        else pass_cnt++;
        queue_bytes(RS_N - 1, 1, 41);
        send_bytes(RS_N * CE + 64);
        check_cnt++;
        if (send_timeout !== 1'b0) $display("[TB] FAIL block3 send: got timeout, expected completion");
        else pass_cnt++;
        repeat (3) tick();
        check_cnt++;
        if (ce_cyc_q.size() - b !== RS_N) $display("[TB] FAIL block3 strobe count: got %0d, expected %0d", ce_cyc_q.size() - b, RS_N);
        else pass_cnt++;
        check_cnt++;
        if (ce_dat_q.size() <= b) $display("[TB] FAIL block3 byte0: got no strobe, expected 5a");
        else if (ce_dat_q[b] !== 8'h5A) $display("[TB] FAIL block3 byte0: got %h, expected 5a", ce_dat_q[b]);
        else pass_cnt++;
        check_cnt++;
        if ({blk_in_cnt, blk_out_cnt} !== {(STATS ? 16'd3 : 16'd0), (STATS ? 16'd1 : 16'd0)})
            $display("[TB] FAIL stats after block3: got in=%0d out=%0d, expected in=%0d out=%0d",
                     blk_in_cnt, blk_out_cnt, STATS ? 3 : 0, STATS ? 1 : 0);
        else pass_cnt++;
    endtask

    task automatic test_sync_err();
        int sb, rb, a, b;
        emit_block(100);
        tick();
        queue_bytes(50, 0, 7);
        send_bytes(50 * CE + 40);
        check_cnt++;
        if (send_timeout !== 1'b0) $display("[TB] FAIL partial block send: got timeout, expected completion");
        else pass_cnt++;
        repeat (4) tick();
        sb = sync_cnt;
        rb = drst_cnt;
        tx_d.push_back(8'hC3);
        tx_s.push_back(1'b1);
        send_bytes(20);
        a = last_acc_cyc;
        b = ce_cyc_q.size();
        check_cnt++;
        if (send_timeout !== 1'b0) $display("[TB] FAIL misaligned sof send: got timeout, expected accept");
        else pass_cnt++;
        queue_bytes(2 * RS_N - 1, 1, 77);
        send_bytes((2 * RS_N - 1) * CE + 80);
        check_cnt++;
        if (send_timeout !== 1'b0) $display("[TB] FAIL post-resync send: got timeout, expected completion");
        else pass_cnt++;
        repeat (3) tick();
        check_cnt++;
        if (sync_cnt - sb !== 1) $display("[TB] FAIL sync_err pulses: got %0d, expected 1", sync_cnt - sb);
        else pass_cnt++;
        check_cnt++;
        if (drst_cnt - rb !== 6) $display("[TB] FAIL resync dec_reset cycles: got %0d, expected 6", drst_cnt - rb);
        else pass_cnt++;
        check_cnt++;
        if (ce_cyc_q.size() - b !== 2 * RS_N) $display("[TB] FAIL post-resync strobes: got %0d, expected %0d", ce_cyc_q.size() - b, 2 * RS_N);
        else pass_cnt++;
        check_cnt++;
        if (ce_dat_q.size() <= b) $display("[TB] FAIL replayed byte: got no strobe, expected c3");
        else if ({ce_dat_q[b], ce_cyc_q[b]} !== {8'hC3, a + 8})
            $display("[TB] FAIL replayed byte: got %h at cycle %0d, expected c3 at cycle %0d", ce_dat_q[b], ce_cyc_q[b], a + 8);
        else pass_cnt++;
        tx_d.push_back(8'h47);
        tx_s.push_back(1'b1);
        send_bytes(24);
        check_cnt++;
        if (send_timeout !== 1'b1) $display("[TB] FAIL stall after two blocks: got accepted, expected s_ready low");
        else pass_cnt++;
        check_cnt++;
        if ({blk_in_cnt, blk_out_cnt, sync_err_cnt} !==
            {(STATS ? 16'd5 : 16'd0), (STATS ? 16'd2 : 16'd0), (STATS ? 16'd1 : 16'd0)})
            $display("[TB] FAIL stats after resync: got in=%0d out=%0d sync=%0d, expected in=%0d out=%0d sync=%0d",
                     blk_in_cnt, blk_out_cnt, sync_err_cnt, STATS ? 5 : 0, STATS ? 2 : 0, STATS ? 1 : 0);
        else pass_cnt++;
    endtask

    task automatic test_gaps();
        int b;
        logic [7:0] v;
        for (int k = 0; k < 10; k++) begin
            b = ce_cyc_q.size();
            v = 8'((k * 19 + 1) & 255);
            tx_d.push_back(v);
            tx_s.push_back(k == 0);
            send_bytes(40);
            check_cnt++;
            if (send_timeout !== 1'b0) $display("[TB] FAIL gap byte %0d send: got timeout, expected accept", k);
            else pass_cnt++;
            repeat (20) tick();
            check_cnt++;
            if (ce_cyc_q.size() - b !== 1) $display("[TB] FAIL gap byte %0d strobes: got %0d, expected 1", k, ce_cyc_q.size() - b);
            else if (ce_dat_q[b] !== v) $display("[TB] FAIL gap byte %0d dec_in: got %h, expected %h", k, ce_dat_q[b], v);
            else pass_cnt++;
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        tick();
        test_reset("power-up");
        test_block();
        test_back_to_back();
        test_output();
        test_sync_err();
        test_reset("resync-stall");
        test_gaps();
        test_reset("mid-block");
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/rs_dec_feeder.md
Name: rs_dec_feeder

Overview:
- Sequencing controller in front of the RS(204,188) decoder (RS_dec).
- Accepts a valid/ready byte stream and produces the decoder's paced CE strobe, holding the input byte stable between strobes.
- Drives the decoder's active-high reset at power-up and on loss of frame sync.
- Frames decoder output into 188-byte blocks with sof/eof, and bounds the number of codewords in flight.

Parameters:
- CE_PERIOD, 8, clocks between successive dec_ce pulses; legal range 8..255.
- RST_CYCLES, 6, clocks dec_reset is held after reset release or a resync.
- MAX_INFLIGHT, 2, codewords fully input but not yet fully output before new block input stalls; legal range 1..7.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- s_data  in  8  upstream codeword byte.
- s_valid  in  1  s_data valid.
- s_sof  in  1  byte is codeword byte 0.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- dec_reset  out  1  to RS_dec.reset, active high.
- dec_ce  out  1  to RS_dec.CE, one-cycle strobe.
- dec_in  out  8  to RS_dec.input_byte.
- dec_out  in  8  from RS_dec.Out_byte.
- dec_ceo  in  1  from RS_dec.CEO.
- dec_valid  in  1  from RS_dec.Valid_out.
- m_data  out  8  decoded byte.
- m_valid  out  1  one-cycle strobe per decoded byte.
- m_sof  out  1  with m_valid, first byte of a 188-byte block.
- m_eof  out  1  with m_valid, byte 187.
- sync_err  out  1  one-cycle pulse on misaligned s_sof.
- blk_in_cnt  out  16  statistics output (see Optional Feature).
- blk_out_cnt  out  16  statistics output.
- sync_err_cnt  out  16  statistics output.

Behaviour:
- Reset state (reset low): dec_reset=1; all other outputs 0; counters 0; FSM=FLUSH.
- FSM states: FLUSH, SETTLE, IDLE, STROBE, GAP.
- FLUSH: dec_reset=1 for RST_CYCLES clocks, then SETTLE.
  - Entry clears in_cnt, out_cnt and inflight.
- SETTLE: dec_reset=0 for 2 clocks.
  - Then STROBE if a byte is pending, else IDLE.
- IDLE: s_ready = (in_cnt!=0) || (inflight<MAX_INFLIGHT).
  - On accept, s_data is registered into dec_in.
  - Normal case: go to STROBE.
  - Case s_sof=1 && in_cnt!=0: pulse sync_err, set pending, go to FLUSH. The accepted byte is kept in dec_in and strobed after SETTLE as byte 0.
  - An s_sof with in_cnt==0, or an in_cnt==0 byte without s_sof, is accepted as a normal byte.
- STROBE: dec_ce=1 for exactly one clock.
  - in_cnt increments; at 203 it wraps to 0 and the block counts as input.
  - Then GAP.
- GAP: CE_PERIOD-2 clocks, then IDLE.
  - Minimum dec_ce spacing is therefore CE_PERIOD.
- dec_in changes only on accept; it is stable from the strobe until the next accept. s_ready=0 outside IDLE.
- Output side:
  - On dec_ceo && dec_valid, the next clock gives m_valid=1 and m_data=dec_out (1-cycle registered latency).
  - m_sof=1 when out_cnt==0; m_eof=1 when out_cnt==187.
  - out_cnt wraps 187->0.
  - There is no backpressure on the output side.
- inflight counter:
  - Increments when an input block completes; decrements on an m_eof emission.
  - Both in the same cycle: unchanged.
  - Decrement at 0 is ignored (no underflow).
- Asynchronous reset mid-operation aborts any block and re-enters FLUSH.
- Upstream bytes held while s_ready=0 are not lost.

Optional Feature:
- Macro: RS_FEED_STATS_EN.
- Defined:
  - blk_in_cnt counts completed input blocks.
  - blk_out_cnt counts m_eof emissions.
  - sync_err_cnt counts sync_err pulses.
  - All three are 16-bit and saturate at 0xFFFF; they are cleared only by reset (not by resync).
- Undefined: all three ports are tied to 0 and no counter logic is built.

Decomposition:
- Package rs_dec_pkg holds:
  - RS_N=204, RS_K=188, CE_PERIOD_MIN=8.
  - Feeder FSM state enum.
  - Counter width constants.
- Sub-module rs_dec_out_framer holds the output register, out_cnt and sof/eof generation, and exports an eof pulse for the inflight counter.

Test Plan:
- Reset release:
  - Required: dec_reset high for 6 clocks after release.
  - Required: s_ready first high 3+6+2 clocks after reset.
- 204 bytes with s_valid held high and s_sof on byte 0:
  - Required: 204 dec_ce pulses exactly 8 clocks apart.
  - Required: dec_in matches each byte at its strobe; blk_in_cnt=1.
- Three back-to-back blocks with MAX_INFLIGHT=2 and no decoder output:
  - Required: s_ready stays low at the start of block 3 until an m_eof occurs.
- Decoder output stub, 188 dec_ceo&&dec_valid pulses with values 0..187:
  - Required: m_valid one clock later with matching data.
  - Required: m_sof on 0, m_eof on 187; inflight decrements.
- s_sof at in_cnt=50:
  - Required: one sync_err pulse and 6-clock dec_reset.
  - Required: that byte is strobed as byte 0; in_cnt=1 afterwards; sync_err_cnt=1 with RS_FEED_STATS_EN defined.
- s_valid gaps plus reset asserted mid-block:
  - Required: no dec_ce while stalled.
  - Required: after reset, all counters 0 and the FLUSH sequence repeats.
